// File: rtl/riscv_axi_rd_arbiter.sv
// Round-robin arbiter sharing one AXI4 read master (AR/R) between iBus (0) and dBus (1).
// Define RD_ARB_PERF_EN to add saturating transaction, beat and wait counters.
module riscv_axi_rd_arbiter #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 32
) (
    input  logic              ap_clk,
    input  logic              areset,

    input  logic              s0_arvalid,
    output logic              s0_arready,
    input  logic [ADDR_W-1:0] s0_araddr,
    input  logic [7:0]        s0_arlen,
    output logic              s0_rvalid,
    input  logic              s0_rready,
    output logic [DATA_W-1:0] s0_rdata,
    output logic              s0_rlast,

    input  logic              s1_arvalid,
    output logic              s1_arready,
    input  logic [ADDR_W-1:0] s1_araddr,
    input  logic [7:0]        s1_arlen,
    output logic              s1_rvalid,
    input  logic              s1_rready,
    output logic [DATA_W-1:0] s1_rdata,
    output logic              s1_rlast,

    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    output logic [ADDR_W-1:0] m_axi_araddr,
    output logic [7:0]        m_axi_arlen,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready,
    input  logic [DATA_W-1:0] m_axi_rdata,
    input  logic              m_axi_rlast,

    output logic [1:0]        grant,
`ifdef RD_ARB_PERF_EN
    output logic [31:0]       perf_txn0,
    output logic [31:0]       perf_txn1,
    output logic [31:0]       perf_beats,
    output logic [31:0]       perf_wait1,
`endif
    output logic              busy
);

    typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

    state_e     state_q, state_d;
    logic [1:0] grant_q, grant_d;
    // Index of the requester served last; 1 at reset so requester 0 wins the first tie.
    logic       last_grant_q, last_grant_d;

    logic in_addr, in_data, r_hs;

    assign in_addr = (state_q == StAddr);
    assign in_data = (state_q == StData);
    assign r_hs    = m_axi_rvalid & m_axi_rready;

    always_ff @(posedge ap_clk) begin
        if (areset) begin
            state_q      <= StIdle;
            grant_q      <= 2'b00;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        case (state_q)
            StIdle: begin
                if (s0_arvalid || s1_arvalid) begin
                    if (s0_arvalid && s1_arvalid) begin
                        grant_d = last_grant_q ? 2'b01 : 2'b10;
                    end else begin
                        grant_d = s1_arvalid ? 2'b10 : 2'b01;
                    end
                    state_d = StAddr;
                end
            end
            StAddr: begin
                if (m_axi_arready) begin
                    state_d = StData;
                end
            end
            StData: begin
                if (r_hs && m_axi_rlast) begin
                    state_d      = StIdle;
                    grant_d      = 2'b00;
                    last_grant_d = grant_q[1];
                end
            end
            default: begin
                state_d = StIdle;
                grant_d = 2'b00;
            end
        endcase
    end

    // Address mux follows the registered grant, so it reads zero while idle.
    always_comb begin
        m_axi_araddr = '0;
        m_axi_arlen  = '0;
        if (grant_q[0]) begin
            m_axi_araddr = s0_araddr;
            m_axi_arlen  = s0_arlen;
        end else if (grant_q[1]) begin
            m_axi_araddr = s1_araddr;
            m_axi_arlen  = s1_arlen;
        end
    end

    assign m_axi_arvalid = in_addr;
    assign s0_arready    = in_addr & grant_q[0] & m_axi_arready;
    assign s1_arready    = in_addr & grant_q[1] & m_axi_arready;

    assign s0_rvalid    = in_data & grant_q[0] & m_axi_rvalid;
    assign s1_rvalid    = in_data & grant_q[1] & m_axi_rvalid;
    assign m_axi_rready = in_data & ((grant_q[0] & s0_rready) | (grant_q[1] & s1_rready));

    assign s0_rdata = m_axi_rdata;
    assign s1_rdata = m_axi_rdata;
    assign s0_rlast = m_axi_rlast;
    assign s1_rlast = m_axi_rlast;

    assign grant = grant_q;
    assign busy  = (state_q != StIdle);

`ifdef RD_ARB_PERF_EN
    logic [31:0] txn0_q, txn1_q, beats_q, wait1_q;
    logic        ar_hs;

    assign ar_hs = in_addr & m_axi_arready;

    always_ff @(posedge ap_clk) begin
        if (areset) begin
            txn0_q  <= '0;
            txn1_q  <= '0;
            beats_q <= '0;
            wait1_q <= '0;
        end else begin
            if (ar_hs && grant_q[0] && txn0_q != '1) txn0_q <= txn0_q + 32'd1;
            if (ar_hs && grant_q[1] && txn1_q != '1) txn1_q <= txn1_q + 32'd1;
            if (in_data && r_hs && beats_q != '1) beats_q <= beats_q + 32'd1;
            if (s1_arvalid && grant_q != 2'b01 && wait1_q != '1) begin
                wait1_q <= wait1_q + 32'd1;
            end
        end
    end

    assign perf_txn0  = txn0_q;
    assign perf_txn1  = txn1_q;
    assign perf_beats = beats_q;
    assign perf_wait1 = wait1_q;
`endif

endmodule

// File: tb/tb_riscv_axi_rd_arbiter.sv
// Self-checking bench for riscv_axi_rd_arbiter: random AXI slave/requester timing checked
// against a transaction-level round-robin model.
module tb_riscv_axi_rd_arbiter;

    localparam int unsigned ADDR_W = 64;
    localparam int unsigned DATA_W = 32;

    logic              ap_clk, areset;
    logic              s0_arvalid, s0_arready, s0_rvalid, s0_rready, s0_rlast;
    logic [ADDR_W-1:0] s0_araddr;
    logic [7:0]        s0_arlen;
    logic [DATA_W-1:0] s0_rdata;
    logic              s1_arvalid, s1_arready, s1_rvalid, s1_rready, s1_rlast;
    logic [ADDR_W-1:0] s1_araddr;
    logic [7:0]        s1_arlen;
    logic [DATA_W-1:0] s1_rdata;
    logic              m_axi_arvalid, m_axi_arready, m_axi_rvalid, m_axi_rready, m_axi_rlast;
    logic [ADDR_W-1:0] m_axi_araddr;
    logic [7:0]        m_axi_arlen;
    logic [DATA_W-1:0] m_axi_rdata;
    logic [1:0]        grant;
    logic              busy;
`ifdef RD_ARB_PERF_EN
    logic [31:0]       perf_txn0, perf_txn1, perf_beats, perf_wait1;
`endif

    riscv_axi_rd_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .ap_clk(ap_clk), .areset(areset),
        .s0_arvalid(s0_arvalid), .s0_arready(s0_arready), .s0_araddr(s0_araddr),
        .s0_arlen(s0_arlen), .s0_rvalid(s0_rvalid), .s0_rready(s0_rready),
        .s0_rdata(s0_rdata), .s0_rlast(s0_rlast),
        .s1_arvalid(s1_arvalid), .s1_arready(s1_arready), .s1_araddr(s1_araddr),
        .s1_arlen(s1_arlen), .s1_rvalid(s1_rvalid), .s1_rready(s1_rready),
        .s1_rdata(s1_rdata), .s1_rlast(s1_rlast),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rlast(m_axi_rlast),
        .grant(grant),
`ifdef RD_ARB_PERF_EN
        .perf_txn0(perf_txn0), .perf_txn1(perf_txn1),
        .perf_beats(perf_beats), .perf_wait1(perf_wait1),
`endif
        .busy(busy)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    wire [1:0] s_arready = {s1_arready, s0_arready};
    wire [1:0] s_rvalid  = {s1_rvalid, s0_rvalid};
    wire [1:0] s_rready  = {s1_rready, s0_rready};

    int checks = 0;
    int errors = 0;

    // Requester-side model: outstanding request per port and beats received so far.
    bit              pend[2];
    logic [63:0]     req_addr[2];
    logic [7:0]      req_len[2];
    int              beat[2];
    int              owner, last_owner;
    // Slave-side model.
    bit              s_busy, rv_held;
    logic [63:0]     s_addr;
    int              s_len, s_idx;
    // Scenario knobs and bookkeeping.
    bit              stall, gaps, late_en, idle_chk;
    int              beats_total, cyc, first_arv;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] word(input logic [63:0] a, input int i);
        return a[31:0] + 32'(i) * 32'h0101_0101;
    endfunction

    task automatic issue(input int i, input logic [63:0] a, input logic [7:0] l);
        pend[i]     = 1'b1;
        req_addr[i] = a;
        req_len[i]  = l;
    endtask

    task automatic model_reset();
        pend[0] = 0; pend[1] = 0; owner = -1; last_owner = 1;
        s_busy = 0; rv_held = 0; idle_chk = 0; late_en = 0;
    endtask

    task automatic quiet_inputs();
        s0_arvalid = 0; s0_araddr = '0; s0_arlen = '0; s0_rready = 0;
        s1_arvalid = 0; s1_araddr = '0; s1_arlen = '0; s1_rready = 0;
        m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rdata = '0; m_axi_rlast = 0;
    endtask

    task automatic do_reset();
        @(negedge ap_clk);
        areset = 1'b1;
        quiet_inputs();
        @(negedge ap_clk);
        areset = 1'b0;
        model_reset();
        #1;
        chk("rst_grant", 64'(grant), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_m_arvalid", 64'(m_axi_arvalid), 64'd0);
        chk("rst_m_rready", 64'(m_axi_rready), 64'd0);
        chk("rst_m_araddr", m_axi_araddr, 64'd0);
        chk("rst_m_arlen", 64'(m_axi_arlen), 64'd0);
        chk("rst_s_arready", 64'(s_arready), 64'd0);
        chk("rst_s_rvalid", 64'(s_rvalid), 64'd0);
    endtask

    // One clock: drive at negedge, check 1ns later, update model.
    task automatic cycle();
        int o;
        @(negedge ap_clk);
        s0_arvalid = pend[0]; s0_araddr = req_addr[0]; s0_arlen = req_len[0];
        s1_arvalid = pend[1]; s1_araddr = req_addr[1]; s1_arlen = req_len[1];
        s0_rready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
        s1_rready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
        m_axi_arready = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
        if (s_busy) begin
            m_axi_rvalid = rv_held ? 1'b1 : (gaps ? ($urandom_range(0, 2) != 0) : 1'b1);
            m_axi_rdata  = word(s_addr, s_idx);
            m_axi_rlast  = (s_idx == s_len);
        end else begin
            m_axi_rvalid = 0; m_axi_rdata = '0; m_axi_rlast = 0;
        end
        #1;
        if (idle_chk) begin
            chk("idle_grant", 64'(grant), 64'd0);
            chk("idle_busy", 64'(busy), 64'd0);
            idle_chk = 0;
        end
        if (first_arv < 0 && m_axi_arvalid) first_arv = cyc;
        if (m_axi_arvalid && m_axi_arready) begin
            if (pend[0] && pend[1]) o = 1 - last_owner;
            else if (pend[0])       o = 0;
            else if (pend[1])       o = 1;
            else                    o = -1;
            if (o < 0) begin
                chk("ar_unrequested", 64'(m_axi_arvalid), 64'd0);
            end else begin
                chk("ar_grant", 64'(grant), 64'd1 << o);
                chk("ar_addr", m_axi_araddr, req_addr[o]);
                chk("ar_len", 64'(m_axi_arlen), 64'(req_len[o]));
                chk("ar_ready_route", 64'(s_arready), 64'd1 << o);
                pend[o] = 0; owner = o; beat[o] = 0;
                s_busy = 1; s_addr = m_axi_araddr; s_len = int'(m_axi_arlen); s_idx = 0;
            end
        end else if (!m_axi_arvalid) begin
            chk("arready_quiet", 64'(s_arready), 64'd0);
        end
        if (owner >= 0 && m_axi_rvalid) begin
            o = owner;
            chk("rvalid_route", 64'(s_rvalid), 64'd1 << o);
            chk("rready_mirror", 64'(m_axi_rready), 64'(s_rready[o]));
            if (m_axi_rready) begin
                chk("rdata", 64'(o == 1 ? s1_rdata : s0_rdata), 64'(word(req_addr[o], beat[o])));
                chk("rlast", 64'(o == 1 ? s1_rlast : s0_rlast),
                    64'(beat[o] == int'(req_len[o])));
                rv_held = 0;
                beats_total++;
                if (beat[o] == int'(req_len[o])) begin
                    s_busy = 0; last_owner = o; owner = -1; idle_chk = 1;
                end else begin
                    beat[o]++; s_idx++;
                end
            end else begin
                rv_held = 1;
            end
        end else if (!m_axi_rvalid) begin
            chk("rvalid_quiet", 64'(s_rvalid), 64'd0);
        end
        // Optionally inject a competing request while a transaction is in flight.
        if (late_en && owner >= 0 && !pend[1 - owner]) begin
            issue(1 - owner, {32'd0, $urandom}, 8'($urandom_range(0, 5)));
            late_en = 0;
        end
        cyc++;
    endtask

    task automatic run(input int budget, input int stop_beats);
        int n;
        bit timed_out;
        n = 0; cyc = 0; timed_out = 0; first_arv = -1;
        while (pend[0] || pend[1] || owner >= 0 || idle_chk) begin
            if (stop_beats > 0 && beats_total >= stop_beats) break;
            if (n == budget) begin
                timed_out = 1;
                break;
            end
            n++;
            cycle();
        end
        chk("run_budget", 64'(timed_out), 64'd0);
    endtask

    initial begin
        int target;
        areset = 1'b1;
        quiet_inputs();
        model_reset();
        stall = 0; gaps = 0; beats_total = 0; first_arv = -1;
        repeat (2) @(posedge ap_clk);
        do_reset();

        // Single s0 burst: one-cycle arbitration bubble, four beats.
        issue(0, 64'h1000, 8'd3);
        run(100, 0);
        chk("ar_latency", 64'(first_arv), 64'd1);

        // Simultaneous pairs out of reset, then an s0-only txn to flip priority.
        do_reset();
        issue(0, 64'h2000, 8'd3); issue(1, 64'h3000, 8'd3);
        run(200, 0);
        issue(0, 64'h2100, 8'd1); issue(1, 64'h3100, 8'd1);
        run(200, 0);
        issue(0, 64'h2200, 8'd0);
        run(100, 0);
        issue(0, 64'h2300, 8'd2); issue(1, 64'h3300, 8'd2);
        run(200, 0);

        // Long s1 burst with valid gaps and ready stalls.
        stall = 1; gaps = 1;
        issue(1, 64'h4000, 8'd7);
        run(500, 0);

        // Single-beat alternation, 10 per requester.
        stall = 0; gaps = 0;
        for (int i = 0; i < 10; i++) begin
            issue(0, 64'h5000 + 64'(i * 4), 8'd0);
            issue(1, 64'h6000 + 64'(i * 4), 8'd0);
            run(100, 0);
        end

        // Random traffic, including requests that arrive mid-transaction.
        for (int i = 0; i < 30; i++) begin
            stall = 1'($urandom_range(0, 1));
            gaps  = 1'($urandom_range(0, 1));
            late_en = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) != 1) issue(0, {32'd0, $urandom}, 8'($urandom_range(0, 7)));
            if ($urandom_range(0, 2) != 0 || !pend[0]) begin
                issue(1, {32'd0, $urandom}, 8'($urandom_range(0, 7)));
            end
            run(2000, 0);
        end

        // Reset after two of four beats, then a fresh s0 read.
        stall = 0; gaps = 0; late_en = 0;
        issue(0, 64'h7000, 8'd3);
        target = beats_total + 2;
        run(100, target);
        chk("mid_owner", 64'(grant), 64'd1);
        do_reset();
        issue(0, 64'h8000, 8'd3);
        run(100, 0);

`ifdef RD_ARB_PERF_EN
        do_reset();
        issue(0, 64'h9000, 8'd3); issue(1, 64'hA000, 8'd3);
        run(200, 0);
        chk("perf_txn0", 64'(perf_txn0), 64'd1);
        chk("perf_txn1", 64'(perf_txn1), 64'd1);
        chk("perf_beats", 64'(perf_beats), 64'd8);
        chk("perf_wait1_nz", 64'(perf_wait1 != 32'd0), 64'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/riscv_axi_rd_arbiter.md
Name: riscv_axi_rd_arbiter

Overview:
- Two-requester arbiter that shares one AXI4 read master (AR and R channels only) between the VexRiscv iBus (requester 0) and dBus (requester 1) read paths.
- Sits between the core bus adapters and the m01_axi read-only port of the kernel top. The m01 write channels stay tied off at the top level.
- Round-robin grant with one outstanding transaction; the grant is held until the last R beat of the granted burst.

Parameters:
- ADDR_W, 64, AXI address width.
- DATA_W, 32, AXI read data width.

Ports:
- ap_clk  in  1  clock
- areset  in  1  synchronous active-high reset
- sN_arvalid  in  1  requester N (N=0,1) read address valid
- sN_arready  out  1  requester N read address ready
- sN_araddr  in  ADDR_W  requester N read address
- sN_arlen  in  8  requester N burst length minus 1
- sN_rvalid  out  1  requester N read data valid
- sN_rready  in  1  requester N read data ready
- sN_rdata  out  DATA_W  requester N read data
- sN_rlast  out  1  requester N last beat
- m_axi_arvalid  out  1  master read address valid
- m_axi_arready  in  1  master read address ready
- m_axi_araddr  out  ADDR_W  master read address
- m_axi_arlen  out  8  master burst length
- m_axi_rvalid  in  1  master read data valid
- m_axi_rready  out  1  master read data ready
- m_axi_rdata  in  DATA_W  master read data
- m_axi_rlast  in  1  master last beat
- grant  out  2  one-hot current owner, 00 when idle
- busy  out  1  transaction in flight (state != IDLE)

Behaviour:
- Clock is ap_clk. Reset is areset, synchronous, active-high.
- Reset values:
  - state=IDLE, grant=00, last_grant=1 (requester 0 wins the first tie).
  - All valid/ready outputs 0.
  - m_axi_araddr and m_axi_arlen are 0.
- IDLE:
  - If any sN_arvalid is high, pick the winner: with both requesting, the requester that is not last_grant wins; otherwise the single requester wins.
  - Register the grant and go to ADDR on the next edge.
  - With no request, stay in IDLE.
- ADDR:
  - m_axi_arvalid=1. m_axi_araddr and m_axi_arlen are muxed from the granted requester's inputs, which it holds stable per AXI rules.
  - s[g]_arready = m_axi_arready. The non-granted sN_arready=0.
  - On m_axi_arvalid & m_axi_arready, go to DATA.
- DATA:
  - s[g]_rvalid = m_axi_rvalid. m_axi_rready = s[g]_rready. The non-granted sN_rvalid=0.
  - rdata and rlast are broadcast to both requesters; they are qualified only by rvalid.
  - On an R handshake with m_axi_rlast=1: go to IDLE, set last_grant=g, clear grant.
- Latency:
  - arvalid asserted into IDLE at edge k -> m_axi_arvalid=1 at edge k+1 (1-cycle arbitration bubble).
  - Minimum back-to-back transaction spacing is one IDLE cycle after the last beat.
- Boundaries:
  - arlen=0: single beat, rlast expected on the first beat.
  - A request arriving during ADDR/DATA waits; its sN_arready stays 0.
  - Dropping sN_arvalid while granted in ADDR is a protocol violation and is not recovered; the arbiter keeps presenting the stale request.
  - A missing rlast keeps the arbiter in DATA indefinitely.
  - Reset mid-burst returns the arbiter to IDLE immediately. Draining any beats still in flight is the responsibility of the system-level reset.
- Combinational paths: ready and valid pass through only. No path exists from sN_arvalid to m_axi_arvalid in the same cycle.

Optional Feature:
- Macro RD_ARB_PERF_EN.
- Defined:
  - Adds outputs perf_txn0, perf_txn1 (32 bits): granted AR handshakes per requester.
  - Adds output perf_beats (32 bits): total R handshakes.
  - Adds output perf_wait1 (32 bits): cycles where s1_arvalid=1 and grant!=01.
  - All counters saturate at FFFFFFFF and reset to 0.
- Undefined: the ports and logic are absent. Arbitration behaviour is identical either way.

Test Plan:
- Only s0 requests, addr 0x1000, arlen=3, slave returns 4 beats -> m_axi_arvalid one cycle after request; 4 beats on s0 with rlast on beat 4; s1_rvalid stays 0; grant returns to 00.
- s0 and s1 request together out of reset -> s0 served first; s1 served next after one IDLE cycle; a third simultaneous request pair grants s1 first again only if s0 was last, confirming alternation.
- s1 burst arlen=7 with m_axi_rvalid gaps and s1_rready stalls -> m_axi_rready mirrors s1_rready; all 8 data words are delivered in order; no beat is lost.
- arlen=0 reads alternated from s0/s1, 10 each -> 20 single-beat transactions; grant alternates when both are pending.
- areset asserted in DATA after 2 of 4 beats -> next cycle state IDLE, grant=00, busy=0, all outputs 0; a fresh s0 request completes normally.
- With RD_ARB_PERF_EN defined: the previous scenario-2 traffic (one burst each, arlen=3) -> perf_txn0=1, perf_txn1=1, perf_beats=8, perf_wait1>0.
